// File: rtl/dtcm_banked_ctrl_pkg.sv
// Shared constants and helpers for the banked DTCM controller.
package dtcm_banked_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Index width that never collapses to zero, so single-entry selects stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtcm_banked_ctrl_bank.sv
// One DTCM bank: byte-masked synchronous-write RAM with a registered read address.
module dtcm_bank
  import dtcm_banked_ctrl_pkg::*;
#(
  parameter int DW           = 32,
  parameter int DEPTH        = 8192,
  parameter int RW           = 13,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [RW-1:0]     addr,
  input  logic [DW-1:0]     din,
  input  logic [DW/8-1:0]   wem,
  output logic [DW-1:0]     dout
);

  localparam int MW = DW / BYTE_W;

  logic [DW-1:0] mem [DEPTH];
  logic [RW-1:0] addr_r;
  logic [DW-1:0] q;

  // Write lands first, then the registered address reads it: read-after-write needs no bypass.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < MW; i++) begin
          if (wem[i]) mem[addr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
        end
      end
      addr_r <= addr;
    end
  end

  assign q = mem[addr_r];

  generate
    if (FORCE_X2ZERO != 0) begin : g_x2zero
      // The address register is undefined until the first access; read zero until then.
      logic armed;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  armed <= 1'b0;
        else if (cs) armed <= 1'b1;
      end
      assign dout = armed ? q : '0;
    end else begin : g_raw
      assign dout = q;
    end
  endgenerate

endmodule

// File: rtl/dtcm_banked_ctrl.sv
// Banked DTCM controller: valid/ready command and response ports over word-interleaved banks.
module dtcm_banked_ctrl
  import dtcm_banked_ctrl_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int DP           = 16384,
  parameter int BANKS        = 2,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [DW/8-1:0]   cmd_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err
);

  localparam int MW  = DW / BYTE_W;
  localparam int OFS = $clog2(MW);
  localparam int WW  = AW - OFS;
  localparam int BL  = $clog2(BANKS);
  localparam int BW  = idx_w(BANKS);
  localparam int RD  = DP / BANKS;
  localparam int RW  = idx_w(RD);

  logic [WW-1:0]  word;
  logic [BW-1:0]  cmd_bank;
  logic [RW-1:0]  row;
  logic           misal;
  logic           oor;
  logic           cmd_err;
  logic           fire;
  logic [BANKS-1:0] bank_cs;
  logic [BANKS-1:0] bank_we;
  logic [DW-1:0]  bank_dout [BANKS];

  logic           s1_valid;
  logic           s1_read;
  logic [BW-1:0]  s1_bank;
  logic           s1_err;
  logic [DW-1:0]  s1_sel;
  logic [DW-1:0]  s1_data;

  logic           hold_valid;
  logic [DW-1:0]  hold_data;
  logic           hold_err;

  assign word = cmd_addr[AW-1:OFS];
  assign row  = word[BL +: RW];
  assign oor  = 32'(word) >= 32'(DP);

  generate
    if (OFS > 0) begin : g_align
      assign misal = |cmd_addr[OFS-1:0];
    end else begin : g_noalign
      assign misal = 1'b0;
    end

    if (BANKS > 1) begin : g_bsel
      assign cmd_bank = word[BW-1:0];
      assign s1_sel   = bank_dout[s1_bank];
    end else begin : g_bsel1
      assign cmd_bank = '0;
      assign s1_sel   = bank_dout[0];
    end
  endgenerate

  assign cmd_err   = misal | oor;
  // Only a full hold buffer blocks: S1 can always spill into it.
  assign cmd_ready = !hold_valid;
  assign fire      = cmd_valid & cmd_ready;

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign bank_cs[b] = fire & !cmd_err & (cmd_bank == BW'(b));
      assign bank_we[b] = bank_cs[b] & !cmd_read;

      dtcm_bank #(
        .DW           (DW),
        .DEPTH        (RD),
        .RW           (RW),
        .FORCE_X2ZERO (FORCE_X2ZERO)
      ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (bank_cs[b]),
        .we    (bank_we[b]),
        .addr  (row),
        .din   (cmd_wdata),
        .wem   (cmd_wmask),
        .dout  (bank_dout[b])
      );
    end
  endgenerate

  // ---- S1: accepted command, one cycle after fire ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else if (fire) begin
      s1_valid <= 1'b1;
      s1_err   <= cmd_err;
    end else if (!hold_valid) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      s1_read <= cmd_read;
      s1_bank <= cmd_bank;
    end
  end

  assign s1_data = (s1_valid & s1_read & !s1_err) ? s1_sel : '0;

  // ---- Hold buffer: parks the S1 response while the consumer stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_err   <= 1'b0;
    end else if (hold_valid) begin
      if (rsp_ready) hold_valid <= 1'b0;
    end else if (s1_valid & !rsp_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= s1_data;
      hold_err   <= s1_err;
    end
  end

  always_comb begin
    rsp_valid = s1_valid;
    rsp_rdata = s1_data;
    rsp_err   = s1_err;
    if (hold_valid) begin
      rsp_valid = 1'b1;
      rsp_rdata = hold_data;
      rsp_err   = hold_err;
    end
  end

endmodule

// File: tb/tb_dtcm_banked_ctrl.sv
// Scoreboard bench for dtcm_banked_ctrl: directed scenarios then randomized traffic.
module tb_dtcm_banked_ctrl;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DP    = 4096;
  localparam int BANKS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  dtcm_banked_ctrl #(
    .AW(AW), .DW(DW), .DP(DP), .BANKS(BANKS), .FORCE_X2ZERO(1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_read  (cmd_read),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wmask (cmd_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb [$];
  logic [31:0] mdl [int];
  bit          rnd_rdy = 1'b0;
  logic        we1_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Memory as a plain word array; each command resolved completely at acceptance.
  function automatic exp_t model(input bit rd, input logic [15:0] a,
                                 input logic [31:0] wd, input logic [3:0] wm);
    exp_t        r;
    int          w;
    logic [31:0] cur;
    w   = int'(a) / 4;
    r.d = 32'h0;
    r.e = 1'b0;
    if ((a % 16'd4) != 16'd0 || w >= DP) begin
      r.e = 1'b1;
    end else begin
      cur = mdl.exists(w) ? mdl[w] : 32'h0;
      if (rd) begin
        r.d = cur;
      end else begin
        for (int i = 0; i < 4; i++)
          if (wm[i]) cur[8*i +: 8] = wd[8*i +: 8];
        mdl[w] = cur;
      end
    end
    return r;
  endfunction

  task automatic upd_rdy();
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd_rdy();
  endtask

  task automatic send(input bit rd, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] wm);
    int n;
    bit ok;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wmask = wm;
    cmd_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else begin
        n++;
        @(posedge clk);
        #1;
        upd_rdy();
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout addr=%h cmd_ready=%b required=1", a, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    we1_seen = u_dut.bank_we[1];
    sb.push_back(model(rd, a, wd, wm));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    upd_rdy();
  endtask

  task automatic drain();
    int n;
    rnd_rdy   = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected actual rdata=%h err=%b required=none", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w;
    logic [15:0] a;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    rst_n = 1'b1;
    tick();

    // basic write then read, one-cycle latency
    send(1'b0, 16'h0000, 32'h11223344, 4'hF);
    chk("wr_latency", 32'(rsp_valid), 32'd1);
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    chk("rd_latency", 32'(rsp_valid), 32'd1);
    chk("rd_data_direct", rsp_rdata, 32'h11223344);
    drain();

    // bank interleave
    send(1'b0, 16'h0000, 32'hA, 4'hF);
    chk("we1_wr0", 32'(we1_seen), 32'd0);
    send(1'b0, 16'h0004, 32'hB, 4'hF);
    chk("we1_wr4", 32'(we1_seen), 32'd1);
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    chk("we1_rd0", 32'(we1_seen), 32'd0);
    chk("il_rd0", rsp_rdata, 32'hA);
    send(1'b1, 16'h0004, 32'h0, 4'h0);
    chk("we1_rd4", 32'(we1_seen), 32'd0);
    chk("il_rd4", rsp_rdata, 32'hB);
    drain();

    // byte mask
    send(1'b0, 16'h0008, 32'hFFFFFFFF, 4'hF);
    send(1'b0, 16'h0008, 32'h00000000, 4'b0101);
    send(1'b1, 16'h0008, 32'h0, 4'h0);
    chk("mask_direct", rsp_rdata, 32'hFF00FF00);
    drain();

    // misaligned and out-of-range; erroneous writes must not touch RAM
    send(1'b1, 16'h0002, 32'h0, 4'h0);
    chk("err_misaligned", 32'(rsp_err), 32'd1);
    send(1'b1, 16'h4000, 32'h0, 4'h0);
    chk("err_range", 32'(rsp_err), 32'd1);
    chk("err_range_data", rsp_rdata, 32'd0);
    send(1'b0, 16'h0002, 32'hDEADBEEF, 4'hF);
    send(1'b0, 16'h4000, 32'hDEADBEEF, 4'hF);
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    chk("err_no_corrupt", rsp_rdata, 32'hA);
    drain();

    // backpressure with hold buffer
    rsp_ready = 1'b0;
    send(1'b1, 16'h0000, 32'h0, 4'h0);
    chk("bp_ready_first", 32'(cmd_ready), 32'd1);
    send(1'b1, 16'h0004, 32'h0, 4'h0);
    chk("bp_ready_second", 32'(cmd_ready), 32'd0);
    chk("bp_hold_data", rsp_rdata, 32'hA);
    tick();
    tick();
    chk("bp_ready_stall", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("bp_ready_back", 32'(cmd_ready), 32'd1);
    chk("bp_s1_next", rsp_rdata, 32'hB);
    tick();
    chk("bp_idle", 32'(rsp_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // reset with a response parked in the hold buffer
    rsp_ready = 1'b0;
    send(1'b1, 16'h0004, 32'h0, 4'h0);
    send(1'b1, 16'h0008, 32'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", 32'(rsp_valid), 32'd0);
    end
    send(1'b1, 16'h0004, 32'h0, 4'h0);
    chk("post_rst_data", rsp_rdata, 32'hB);
    drain();

    // randomized traffic over a preloaded window
    for (int i = 0; i < 32; i++) send(1'b0, 16'(i * 4), $urandom, 4'hF);
    drain();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 31);
      if (k == 0)      a = 16'(w * 4 + $urandom_range(1, 3));
      else if (k == 1) a = 16'(16'h4000 + w * 4);
      else             a = 16'(w * 4);
      if ($urandom_range(0, 7) == 0) tick();
      send($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
